link_transmitter: RTL and testbench
===================================

Name: link_transmitter

Overview:
- Output-side link transmitter placed after each switch_fabric output port. It drives one router output channel into the neighbouring router's input queue.
- It is the sending end of the flit link whose receiving end is a fifo input queue written by write_strobe.
- It enforces credit-based flow control against the downstream queue depth.
- It transfers each packet atomically as PACKET_FLITS consecutive flits, and returns a read strobe to the upstream input queue for every accepted flit.

Parameters:
- CHANNEL_WIDTH, 32, flit width; equals `CHANNEL_WIDTH from system.vh.
- CREDIT_DEPTH, 4, depth of the downstream input queue, which is the initial credit count.
- PACKET_FLITS, 5, flits per packet (head flit included); legal range 1..15.
- CNT_WIDTH, 3, credit counter width; must satisfy 2^CNT_WIDTH > CREDIT_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flit_din  in  CHANNEL_WIDTH  flit from the switch_fabric output port.
- flit_valid_din  in  1  upstream queue holds a valid flit for this port (non-empty and scheduled).
- flit_ready_dout  out  1  combinational accept; used as read_strobe of the source queue.
- credit_din  in  1  one-cycle pulse: downstream queue freed one slot.
- channel_dout  out  CHANNEL_WIDTH  registered flit toward the neighbour.
- write_strobe_dout  out  1  registered; high for exactly the cycles channel_dout carries a new flit.
- busy_dout  out  1  packet in progress (FSM not IDLE).
- stall_dout  out  1  FSM in STALL.
- credit_count_dout  out  CNT_WIDTH  current credit count.
- credit_error_dout  out  1  sticky credit-overflow flag.
- packets_sent_dout  out  16  completed packet count; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, any time, including mid-packet):
  - channel_dout=0, write_strobe_dout=0, busy_dout=0, stall_dout=0.
  - credit_count_dout=CREDIT_DEPTH, credit_error_dout=0, packets_sent_dout=0.
  - FSM=IDLE, flit counter=0. A partially sent packet is abandoned; no further flits of it are emitted.
- Accept rule:
  - accept = flit_valid_din & flit_ready_dout.
  - flit_ready_dout = (credit_count != 0) & (state != STALL). It is combinational from registered state only; it never depends on credit_din in the same cycle.
- Datapath:
  - On accept, channel_dout <= flit_din and write_strobe_dout <= 1, giving 1-cycle latency.
  - Without accept, write_strobe_dout <= 0 and channel_dout <= 0.
  - Flit contents are passed unmodified, including bit 30 (done) and bits [29:24] (routing field).
- Credits (next count = count - accept + credit_din):
  - Accept and credit_din in the same cycle leave the count unchanged.
  - credit_din with count==CREDIT_DEPTH and no accept: count stays at CREDIT_DEPTH and credit_error_dout <= 1. The flag is cleared only by reset.
  - The count can never underflow, because accept requires count != 0.
- FSM states: IDLE, SEND, STALL.
  - IDLE: accept of a head flit sets flit counter=1. If PACKET_FLITS==1, packets_sent increments and the FSM stays IDLE; otherwise it goes to SEND (or to STALL if the next count is 0).
  - SEND: each accept increments the flit counter. On the accept that makes counter==PACKET_FLITS, the FSM goes to IDLE, the counter clears to 0 and packets_sent increments. If the next count==0 and the packet is incomplete, it goes to STALL.
  - STALL: no accepts. On credit_din the FSM goes to SEND on the next cycle.
  - flit_valid_din low in SEND: the FSM remains in SEND holding the counter, with no timeout. The port stays locked to the packet.
  - busy_dout=(state!=IDLE); stall_dout=(state==STALL). Both are registered state decodes.
- Back-to-back packets: a head flit may be accepted in the first IDLE cycle after a tail, with no bubble required beyond that IDLE cycle.

Test Plan:
- Reset, then flit_valid_din=1 continuously with flits 0x4000_0100..0x4000_0104 and CREDIT_DEPTH=4, no credits:
  - 4 flits appear on channel_dout, one cycle after each accept; write_strobe_dout high 4 cycles.
  - Then stall_dout=1, credit_count_dout=0 and flit_ready_dout=0.
- Continuing from stall, pulse credit_din once:
  - The FSM returns to SEND, the 5th flit 0x4000_0104 is emitted and busy_dout falls.
  - packets_sent_dout=1, credit_count_dout=0.
- Credits returned every cycle while sending 3 packets back-to-back:
  - credit_count_dout stays 4, with no stall and 15 write strobes.
  - packets_sent_dout=3 and exactly one IDLE cycle between packets.
- credit_din pulse at reset state (count=4) -> credit_count_dout stays 4, credit_error_dout=1 and it stays 1 until reset.
- Assert reset mid-packet after 2 flits:
  - All outputs return to reset values immediately.
  - The next accepted flit is treated as a head; packets_sent counts only after 5 more flits.
- flit_valid_din dropped for 3 cycles mid-packet:
  - write_strobe_dout low, busy_dout=1, channel_dout=0.
  - On resume the remaining flits complete the packet and the counter reaches 5.

Source files
------------

// File: rtl/link_transmitter.sv
// Credit-based flit link transmitter: sends fixed-length packets atomically
// toward a neighbouring router input queue and tracks downstream credits.
module link_transmitter #(
  parameter int unsigned CHANNEL_WIDTH = 32,
  parameter int unsigned CREDIT_DEPTH  = 4,
  parameter int unsigned PACKET_FLITS  = 5,
  parameter int unsigned CNT_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_WIDTH-1:0] flit_din,
  input  logic                     flit_valid_din,
  output logic                     flit_ready_dout,
  input  logic                     credit_din,
  output logic [CHANNEL_WIDTH-1:0] channel_dout,
  output logic                     write_strobe_dout,
  output logic                     busy_dout,
  output logic                     stall_dout,
  output logic [CNT_WIDTH-1:0]     credit_count_dout,
  output logic                     credit_error_dout,
  output logic [15:0]              packets_sent_dout
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned PKT_W  = 16;
  localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDIT_DEPTH);
  localparam logic [FCNT_W-1:0]    LAST_IDX   = FCNT_W'(PACKET_FLITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [FCNT_W-1:0]        r_flit_cnt;
  logic [FCNT_W-1:0]        w_flit_cnt_nxt;
  logic [CNT_WIDTH-1:0]     r_credit;
  logic [CNT_WIDTH-1:0]     w_credit_nxt;
  logic                     r_credit_err;
  logic                     w_credit_err_nxt;
  logic [PKT_W-1:0]         r_pkts;
  logic                     w_pkt_done;
  logic [CHANNEL_WIDTH-1:0] r_channel;
  logic                     r_strobe;
  logic                     r_busy;
  logic                     r_stall;
  logic                     w_ready;
  logic                     w_accept;

  // Ready depends on registered state only, never on same-cycle credit_din.
  always_comb begin
    w_ready  = (r_credit != '0) && (r_state != ST_STALL);
    w_accept = flit_valid_din && w_ready;
  end

  // Credit bookkeeping; a return while already full is flagged, not counted.
  always_comb begin
    w_credit_nxt     = r_credit;
    w_credit_err_nxt = r_credit_err;
    if (w_accept && !credit_din) begin
      w_credit_nxt = r_credit - CNT_WIDTH'(1);
    end else if (!w_accept && credit_din) begin
      if (r_credit == CREDIT_MAX) begin
        w_credit_err_nxt = 1'b1;
      end else begin
        w_credit_nxt = r_credit + CNT_WIDTH'(1);
      end
    end
  end

  // Packet FSM: next state, flit counter and packet completion.
  always_comb begin
    w_state_nxt    = r_state;
    w_flit_cnt_nxt = r_flit_cnt;
    w_pkt_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (PACKET_FLITS == 1) begin
            w_flit_cnt_nxt = '0;
            w_pkt_done     = 1'b1;
          end else begin
            w_flit_cnt_nxt = FCNT_W'(1);
            w_state_nxt    = (w_credit_nxt == '0) ? ST_STALL : ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          if (r_flit_cnt == LAST_IDX) begin
            w_flit_cnt_nxt = '0;
            w_pkt_done     = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_flit_cnt_nxt = r_flit_cnt + FCNT_W'(1);
            if (w_credit_nxt == '0) begin
              w_state_nxt = ST_STALL;
            end
          end
        end
      end
      ST_STALL: begin
        if (credit_din) begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_flit_cnt_nxt = '0;
      end
    endcase
  end

  // State and flit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_flit_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_flit_cnt <= w_flit_cnt_nxt;
    end
  end

  // Credit counter, sticky overflow flag and completed-packet counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit     <= CREDIT_MAX;
      r_credit_err <= 1'b0;
      r_pkts       <= '0;
    end else begin
      r_credit     <= w_credit_nxt;
      r_credit_err <= w_credit_err_nxt;
      if (w_pkt_done) begin
        r_pkts <= r_pkts + PKT_W'(1);
      end
    end
  end

  // Output datapath and state-decode status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_channel <= '0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      r_channel <= w_accept ? flit_din : '0;
      r_strobe  <= w_accept;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_stall   <= (w_state_nxt == ST_STALL);
    end
  end

  assign flit_ready_dout   = w_ready;
  assign channel_dout      = r_channel;
  assign write_strobe_dout = r_strobe;
  assign busy_dout         = r_busy;
  assign stall_dout        = r_stall;
  assign credit_count_dout = r_credit;
  assign credit_error_dout = r_credit_err;
  assign packets_sent_dout = r_pkts;

endmodule

// File: tb/tb_link_transmitter.sv
// Self-checking bench for link_transmitter: directed scenarios plus random
// traffic, all compared against a packet/credit-level reference model.
module tb_link_transmitter;

  localparam int unsigned CW = 32;
  localparam int unsigned CD = 4;
  localparam int unsigned PF = 5;
  localparam int unsigned CNW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [CW-1:0]  flit_din = '0;
  logic           flit_valid_din = 1'b0;
  logic           flit_ready_dout;
  logic           credit_din = 1'b0;
  logic [CW-1:0]  channel_dout;
  logic           write_strobe_dout;
  logic           busy_dout;
  logic           stall_dout;
  logic [CNW-1:0] credit_count_dout;
  logic           credit_error_dout;
  logic [15:0]    packets_sent_dout;

  always #5 clk = ~clk;

  link_transmitter #(
    .CHANNEL_WIDTH(CW),
    .CREDIT_DEPTH (CD),
    .PACKET_FLITS (PF),
    .CNT_WIDTH    (CNW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flit_din         (flit_din),
    .flit_valid_din   (flit_valid_din),
    .flit_ready_dout  (flit_ready_dout),
    .credit_din       (credit_din),
    .channel_dout     (channel_dout),
    .write_strobe_dout(write_strobe_dout),
    .busy_dout        (busy_dout),
    .stall_dout       (stall_dout),
    .credit_count_dout(credit_count_dout),
    .credit_error_dout(credit_error_dout),
    .packets_sent_dout(packets_sent_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: credits held downstream, position inside current packet.
  int            m_credits;
  int            m_pos;
  int            m_pkts;
  bit            m_err;
  bit            m_strobe;
  logic [CW-1:0] m_chan;

  int n_strobes;
  int n_idle;
  int n_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credits = CD;
    m_pos     = 0;
    m_pkts    = 0;
    m_err     = 1'b0;
    m_strobe  = 1'b0;
    m_chan    = '0;
  endtask

  task automatic check_outputs();
    chk("channel",  channel_dout, m_chan);
    chk("strobe",   32'(write_strobe_dout), 32'(m_strobe));
    chk("busy",     32'(busy_dout), 32'(m_pos != 0));
    chk("stall",    32'(stall_dout), 32'(m_pos != 0 && m_credits == 0));
    chk("credits",  32'(credit_count_dout), 32'(m_credits));
    chk("cred_err", 32'(credit_error_dout), 32'(m_err));
    chk("pkts",     32'(packets_sent_dout), 32'(m_pkts % 65536));
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs.
  task automatic cycle(input bit v, input logic [CW-1:0] d, input bit c);
    bit exp_ready;
    bit acc;
    @(negedge clk);
    flit_valid_din = v;
    flit_din       = d;
    credit_din     = c;
    #1;
    exp_ready = (m_credits != 0);
    chk("ready", 32'(flit_ready_dout), 32'(exp_ready));
    acc      = v && exp_ready;
    m_strobe = acc;
    m_chan   = acc ? d : '0;
    if (acc) begin
      m_pos++;
      if (m_pos == PF) begin
        m_pos = 0;
        m_pkts++;
      end
    end
    if (c && !acc && m_credits == CD) m_err = 1'b1;
    else m_credits = m_credits - int'(acc) + int'(c);
    @(posedge clk);
    #1;
    check_outputs();
    if (write_strobe_dout) n_strobes++;
    if (!busy_dout) n_idle++;
    if (stall_dout) n_stall++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    flit_valid_din = 1'b0;
    credit_din     = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_ready", 32'(flit_ready_dout), 32'd1);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Fill all credits, stall, then finish the packet on one returned credit.
    do_reset();
    n_strobes = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h4000_0100 + 32'(i), 1'b0);
    cycle(1'b1, 32'h4000_0104, 1'b0);
    cycle(1'b1, 32'h4000_0104, 1'b0);
    chk("t1_strobes", 32'(n_strobes), 32'd4);
    chk("t1_stall",   32'(stall_dout), 32'd1);
    chk("t1_credit0", 32'(credit_count_dout), 32'd0);
    chk("t1_ready0",  32'(flit_ready_dout), 32'd0);
    cycle(1'b1, 32'h4000_0104, 1'b1);
    cycle(1'b1, 32'h4000_0104, 1'b0);
    chk("t1_tail",    channel_dout, 32'h4000_0104);
    chk("t1_busy",    32'(busy_dout), 32'd0);
    chk("t1_pkts",    32'(packets_sent_dout), 32'd1);

    // Three packets back-to-back with a credit returned every cycle.
    do_reset();
    n_strobes = 0;
    n_idle    = 0;
    n_stall   = 0;
    for (int i = 0; i < 15; i++) cycle(1'b1, $urandom, 1'b1);
    chk("b2b_strobes", 32'(n_strobes), 32'd15);
    chk("b2b_idle",    32'(n_idle), 32'd3);
    chk("b2b_stall",   32'(n_stall), 32'd0);
    chk("b2b_pkts",    32'(packets_sent_dout), 32'd3);
    chk("b2b_credits", 32'(credit_count_dout), 32'd4);

    // Credit returned while already full sets the sticky error.
    do_reset();
    cycle(1'b0, '0, 1'b1);
    chk("ovf_err", 32'(credit_error_dout), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b1);
    chk("ovf_sticky", 32'(credit_error_dout), 32'd1);
    do_reset();

    // Reset mid-packet: the next flit starts a fresh packet.
    cycle(1'b1, 32'h1111_0000, 1'b0);
    cycle(1'b1, 32'h1111_0001, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h2222_0000 + 32'(i), 1'b1);
    chk("mid_pkts4", 32'(packets_sent_dout), 32'd0);
    cycle(1'b1, 32'h2222_0004, 1'b1);
    chk("mid_pkts5", 32'(packets_sent_dout), 32'd1);

    // Upstream goes quiet mid-packet; the port stays locked to it.
    do_reset();
    cycle(1'b1, 32'h7fc0_0001, 1'b1);
    cycle(1'b1, 32'h7fc0_0002, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'hdead_beef, 1'b0);
      chk("gap_strobe", 32'(write_strobe_dout), 32'd0);
      chk("gap_busy",   32'(busy_dout), 32'd1);
      chk("gap_chan",   channel_dout, 32'd0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h7fc0_0003 + 32'(i), 1'b0);
    chk("gap_pkts", 32'(packets_sent_dout), 32'd1);
    chk("gap_idle", 32'(busy_dout), 32'd0);

    // Random traffic with random credit returns (including overflows).
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
